// File: rtl/fetch_pkg.sv
// Shared types and decode helpers for the instruction fetch slice.
// Entry fields are FETCH_XLEN wide; fetch_unit's XLEN must match.
package fetch_pkg;

    localparam int unsigned FETCH_XLEN = 32;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
        logic                  pred;
    } fetch_entry_t;

    // Sign-extended J-type immediate (JAL offset).
    function automatic logic [31:0] j_imm(input logic [31:0] instr);
        return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    // Sign-extended B-type immediate (conditional branch offset).
    function automatic logic [31:0] b_imm(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// First-word-fall-through circular queue of fetch entries.
// Flush clears all entries at the next edge and overrides push/pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fetch_entry_t,
    localparam int unsigned PW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  entry_t        wdata,
    output entry_t        rdata,
    output logic [PW:0]   count,
    output logic          full
);

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (PW+1)'(DEPTH));

    // A push into a full queue is only legal when the head leaves the same cycle.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

    always @(posedge clk) begin
        if (!rst && !flush) begin
            assert (!(push && full && !pop));
            assert (!(pop && empty));
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation, optional static prediction, FWFT fetch queue.
// Define FETCH_PREDICT_EN to enable JAL / backward-branch prediction.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned      XLEN         = 32,
    parameter int unsigned      DEPTH        = 4,
    parameter int unsigned      IMEM_AW      = 12,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [IMEM_AW-1:0]       imem_addr,
    input  logic [XLEN-1:0]          imem_data,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     if_valid,
    input  logic                     if_ready,
    output logic [XLEN-1:0]          if_pc,
    output logic [XLEN-1:0]          if_instr,
    output logic [XLEN-1:0]          if_pc_plus_4,
    output logic                     if_pred_taken,
    output logic [$clog2(DEPTH):0]   occupancy
);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] redirect_target;
    logic            pred;
    logic            push;
    logic            pop;
    logic            q_full;
    fetch_entry_t    wentry;
    fetch_entry_t    head;

    assign seq_pc          = fetch_pc_q + XLEN'(4);
    assign redirect_target = redirect_pc & ~XLEN'(3);

`ifdef FETCH_PREDICT_EN
    logic [6:0]      opcode;
    logic            is_jal;
    logic            is_bwd_branch;
    logic [XLEN-1:0] pred_target;

    assign opcode        = imem_data[6:0];
    assign is_jal        = (opcode == OPC_JAL);
    assign is_bwd_branch = (opcode == OPC_BRANCH) && imem_data[31];
    assign pred          = is_jal || is_bwd_branch;
    assign pred_target   = fetch_pc_q + XLEN'(is_jal ? j_imm(imem_data[31:0])
                                                     : b_imm(imem_data[31:0]));
    assign next_pc       = pred ? pred_target : seq_pc;
`else
    assign pred    = 1'b0;
    assign next_pc = seq_pc;
`endif

    assign pop  = if_valid && if_ready && !redirect_valid;
    assign push = !redirect_valid && (!q_full || pop);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
        end else if (push) begin
            fetch_pc_d = next_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_VECTOR;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign wentry = '{pc: fetch_pc_q, instr: imem_data, pred: pred};

    fetch_queue #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .wdata (wentry),
        .rdata (head),
        .count (occupancy),
        .full  (q_full)
    );

    assign imem_addr     = fetch_pc_q[IMEM_AW+1:2];
    assign if_valid      = (occupancy != '0);
    assign if_pc         = head.pc;
    assign if_instr      = head.instr;
    assign if_pc_plus_4  = head.pc + XLEN'(4);
    // Storage is not reset, so mask the stale pred bit of an empty head.
    assign if_pred_taken = if_valid && head.pred;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: reference stream model plus directed and random stimulus.
module tb_fetch_unit;

    localparam int DEPTH = 4;
    localparam int OW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic [11:0]   imem_addr;
    logic [31:0]   imem_data;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          if_valid;
    logic          if_ready;
    logic [31:0]   if_pc;
    logic [31:0]   if_instr;
    logic [31:0]   if_pc_plus_4;
    logic          if_pred_taken;
    logic [OW-1:0] occupancy;

    logic [31:0] imem [0:4095];

    fetch_unit #(
        .XLEN         (32),
        .DEPTH        (DEPTH),
        .IMEM_AW      (12),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_pc_plus_4   (if_pc_plus_4),
        .if_pred_taken  (if_pred_taken),
        .occupancy      (occupancy)
    );

    assign imem_data = imem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred;
    } exp_t;

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;
    int   delivered;

`ifdef FETCH_PREDICT_EN
    localparam bit PREDICT = 1'b1;
`else
    localparam bit PREDICT = 1'b0;
`endif

    function automatic bit model_pred(input logic [31:0] instr);
        if (!PREDICT) return 1'b0;
        return (instr[6:0] == 7'h6F) || (instr[6:0] == 7'h63 && instr[31]);
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] instr);
        logic signed [20:0] joff;
        logic signed [12:0] boff;
        joff = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        boff = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        if (model_pred(instr)) begin
            if (instr[6:0] == 7'h6F) return pc + 32'(joff);
            return pc + 32'(boff);
        end
        return pc + 32'd4;
    endfunction

    // Expected in-order delivery stream from a start address.
    task automatic load_stream(input logic [31:0] start);
        logic [31:0] pc;
        exp_t        e;
        exp_q.delete();
        pc = start;
        for (int i = 0; i < 256; i++) begin
            e.pc    = pc;
            e.instr = imem[pc[13:2]];
            e.pred  = model_pred(e.instr);
            exp_q.push_back(e);
            pc = model_next(pc, e.instr);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        load_stream(32'h0);
        repeat (n) step();
        rst = 1'b0;
    endtask

    // Monitor: each accepted head must match the next expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && if_valid && if_ready && !redirect_valid) begin
            vectors++;
            delivered++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_empty: got pc %h expected no delivery", if_pc);
            end else begin
                e = exp_q.pop_front();
                if (if_pc !== e.pc || if_instr !== e.instr || if_pc_plus_4 !== e.pc + 32'd4
                    || if_pred_taken !== e.pred) begin
                    miscompares++;
                    $display("FAIL delivery: got pc %h instr %h pc4 %h pred %b expected pc %h instr %h pc4 %h pred %b",
                             if_pc, if_instr, if_pc_plus_4, if_pred_taken,
                             e.pc, e.instr, e.pc + 32'd4, e.pred);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic [31:0] tgt;
        int          d0;
        int          since;
        vectors     = 0;
        miscompares = 0;
        delivered   = 0;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b0;

        for (int i = 0; i < 4096; i++) begin
            r = $urandom;
            imem[i] = {r[31:7], 7'b0010011};
            if (i >= 256 && i < 512) begin
                if (r[2:0] == 3'd0) imem[i] = {r[31:7], 7'h6F};
                else if (r[2:0] == 3'd1) imem[i] = {1'b1, r[30:7], 7'h63};
            end
        end
        imem[8] = 32'hFF9F_F06F;

        // Reset state
        do_reset(3);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_pred", 32'(if_pred_taken), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);

        // Reset release stream
        step();
        rst      = 1'b0;
        if_ready = 1'b1;
        @(negedge clk);
        chk("release_no_push_yet", 32'(if_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("release_pc", if_pc, 32'(4 * i));
            chk("release_pc4", if_pc_plus_4, 32'(4 * i + 4));
        end

        // Stall saturation
        if_ready = 1'b0;
        do_reset(2);
        repeat (10) step();
        @(negedge clk);
        chk("stall_occupancy", 32'(occupancy), 32'(DEPTH));
        chk("stall_imem_addr", 32'(imem_addr), 32'd4);
        @(posedge clk);
        #1;
        if_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_drain_pc", if_pc, 32'(4 * i));
        end

        // Redirect with 3 entries queued
        if_ready = 1'b0;
        do_reset(2);
        repeat (3) step();
        @(negedge clk);
        chk("pre_redirect_occ", 32'(occupancy), 32'd3);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        load_stream(32'h100);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("redirect_occ", 32'(occupancy), 32'd0);
        chk("redirect_bubble", 32'(if_valid), 32'd0);
        @(negedge clk);
        chk("redirect_valid_again", 32'(if_valid), 32'd1);
        chk("redirect_pc", if_pc, 32'h100);
        @(posedge clk);
        #1;
        if_ready = 1'b1;
        repeat (6) step();

        // Reset beats redirect
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        load_stream(32'h0);
        step();
        @(negedge clk);
        chk("rst_vs_redirect_addr", 32'(imem_addr), 32'd0);
        chk("rst_vs_redirect_occ", 32'(occupancy), 32'd0);
        @(posedge clk);
        #1;
        rst            = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_vs_redirect_pc", if_pc, 32'h0);

        // JAL x0,-8 at 0x20
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        load_stream(32'h20);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("jal_pc", if_pc, 32'h20);
        chk("jal_pred", 32'(if_pred_taken), 32'(PREDICT));
        @(negedge clk);
        chk("jal_next_pc", if_pc, PREDICT ? 32'h18 : 32'h24);

        // Address wrap with alternating ready
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF0;
        load_stream(32'hFFFF_FFF0);
        step();
        redirect_valid = 1'b0;
        d0 = delivered;
        for (int i = 0; i < 40; i++) begin
            if_ready = i[0];
            step();
        end
        chk("wrap_delivered_enough", 32'(delivered - d0 >= 3 * DEPTH + 1), 32'd1);

        // Random traffic
        since = 0;
        for (int i = 0; i < 1500; i++) begin
            rst            = 1'b0;
            redirect_valid = 1'b0;
            r = $urandom;
            if_ready = (r[1:0] != 2'd0);
            if (r[15:4] < 12'd16 || since >= 60) begin
                tgt = $urandom;
                redirect_valid = 1'b1;
                redirect_pc    = {20'h0, 2'b01, tgt[9:0]};
                load_stream({20'h0, 2'b01, tgt[9:2], 2'b00});
                since = 0;
            end
            if (r[27:16] < 12'd12) begin
                rst = 1'b1;
                load_stream(32'h0);
                since = 0;
            end
            since++;
            step();
        end
        rst            = 1'b0;
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        repeat (10) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
